// File: rtl/myCPU_pkg.sv
// Shared ALU definitions: operation encodings and datapath width used by the
// ALU, the decoder and the ALU arbiter.
package myCPU_pkg;

    localparam int DATA_WIDTH = 32;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_ADD  = 4'b0000;
    localparam alu_op_t ALU_ADDU = 4'b0001;
    localparam alu_op_t ALU_SLT  = 4'b0010;
    localparam alu_op_t ALU_SLTU = 4'b0011;
    localparam alu_op_t ALU_SUB  = 4'b0100;
    localparam alu_op_t ALU_SUBU = 4'b0101;
    localparam alu_op_t ALU_AND  = 4'b0110;
    localparam alu_op_t ALU_OR   = 4'b0111;
    localparam alu_op_t ALU_XOR  = 4'b1000;
    localparam alu_op_t ALU_NOR  = 4'b1001;
    localparam alu_op_t ALU_SLL  = 4'b1010;
    localparam alu_op_t ALU_SRL  = 4'b1011;
    localparam alu_op_t ALU_SRA  = 4'b1100;

    // Only the signed add/subtract report overflow.
    function automatic logic has_ovf(input alu_op_t op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/myCPU_alu.sv
// Purely combinational ALU. Shifts move B by the amount held in A[4:0].
module myCPU_alu
    import myCPU_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  alu_op_t               ALUop,
    output logic [DATA_WIDTH-1:0] aluResult,
    output logic                  overFlow
);

    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] diff;
    logic                  lt_s;
    logic                  lt_u;

    assign sum  = A + B;
    assign diff = A - B;
    assign lt_s = $signed(A) < $signed(B);
    assign lt_u = A < B;

    always_comb begin
        aluResult = '0;
        overFlow  = 1'b0;
        case (ALUop)
            ALU_ADD: begin
                aluResult = sum;
                overFlow  = (A[DATA_WIDTH-1] == B[DATA_WIDTH-1]) &&
                            (sum[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
            end
            ALU_ADDU: aluResult = sum;
            ALU_SLT:  aluResult = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            ALU_SLTU: aluResult = {{(DATA_WIDTH-1){1'b0}}, lt_u};
            ALU_SUB: begin
                aluResult = diff;
                overFlow  = (A[DATA_WIDTH-1] != B[DATA_WIDTH-1]) &&
                            (diff[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
            end
            ALU_SUBU: aluResult = diff;
            ALU_AND:  aluResult = A & B;
            ALU_OR:   aluResult = A | B;
            ALU_XOR:  aluResult = A ^ B;
            ALU_NOR:  aluResult = ~(A | B);
            ALU_SLL:  aluResult = B << A[4:0];
            ALU_SRL:  aluResult = B >> A[4:0];
            ALU_SRA:  aluResult = $signed(B) >>> A[4:0];
            default: begin
                aluResult = '0;
                overFlow  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/myCPU_rsp_fifo.sv
// Circular response queue with occupancy count; clear empties it in one cycle
// and overrides any push or pop in the same cycle.
module myCPU_rsp_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/mycpu_alu_arb.sv
// Round-robin arbiter in front of the shared ALU: one register stage, then an
// in-order response queue. Acceptance depends only on local occupancy.
module mycpu_alu_arb
    import myCPU_pkg::*;
#(
    parameter int TAG_W     = 4,
    parameter int OUT_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [3:0]            req0_op,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic [TAG_W-1:0]      req0_tag,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [3:0]            req1_op,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    input  logic [TAG_W-1:0]      req1_tag,
    input  logic                  flush,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_ovf
);

    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int ENT_W = 1 + TAG_W + 1 + DATA_WIDTH;

    logic                  rr_ptr;
    logic                  sel;
    logic                  credit;
    logic                  accept;
    logic [CNT_W:0]        occ;
    logic [CNT_W-1:0]      fifo_cnt;

    logic                  s1_valid;
    logic                  s1_id;
    logic [TAG_W-1:0]      s1_tag;
    alu_op_t               s1_op;
    logic [DATA_WIDTH-1:0] s1_a;
    logic [DATA_WIDTH-1:0] s1_b;

    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_ovf;
    logic                  push;
    logic                  pop;
    logic [ENT_W-1:0]      push_data;
    logic [ENT_W-1:0]      head_data;

    // Slot already held by S1 counts against the queue, so S1 can always drain.
    assign occ    = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, s1_valid};
    assign credit = occ < (CNT_W + 1)'(OUT_DEPTH);

    assign sel        = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    assign req0_ready = credit && !flush && !sel;
    assign req1_ready = credit && !flush && sel;
    assign accept     = sel ? (req1_valid && req1_ready) : (req0_valid && req0_ready);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr   <= 1'b0;
            s1_valid <= 1'b0;
            s1_id    <= 1'b0;
            s1_tag   <= '0;
            s1_op    <= ALU_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                rr_ptr <= ~sel;
                s1_id  <= sel;
                s1_tag <= sel ? req1_tag : req0_tag;
                s1_op  <= sel ? req1_op  : req0_op;
                s1_a   <= sel ? req1_a   : req0_a;
                s1_b   <= sel ? req1_b   : req0_b;
            end
        end
    end

    myCPU_alu u_alu (
        .A         (s1_a),
        .B         (s1_b),
        .ALUop     (s1_op),
        .aluResult (alu_res),
        .overFlow  (alu_ovf)
    );

    assign push      = s1_valid && !flush;
    assign pop       = rsp_valid && rsp_ready && !flush;
    assign push_data = {s1_id, s1_tag, alu_ovf && has_ovf(s1_op), alu_res};

    myCPU_rsp_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (ENT_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (flush),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (fifo_cnt)
    );

    // Head fields read as zero while empty so reset/flush leave clean outputs.
    assign rsp_valid  = (fifo_cnt != '0);
    assign rsp_id     = rsp_valid && head_data[ENT_W-1];
    assign rsp_tag    = rsp_valid ? head_data[ENT_W-2 -: TAG_W] : '0;
    assign rsp_ovf    = rsp_valid && head_data[DATA_WIDTH];
    assign rsp_result = rsp_valid ? head_data[DATA_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_mycpu_alu_arb.sv
// Bench for mycpu_alu_arb: directed latency/arbitration/backpressure/flush/reset
// cases, with every delivered response checked against a scoreboard.
`timescale 1ns/1ps
module tb_mycpu_alu_arb;

    localparam int TAG_W = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic [31:0] rsp_result;
    logic        rsp_ovf;

    always #5 clk = ~clk;

    mycpu_alu_arb #(.TAG_W(TAG_W), .OUT_DEPTH(3)) dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_tag(rsp_tag), .rsp_result(rsp_result), .rsp_ovf(rsp_ovf)
    );

    typedef struct packed {
        logic             id;
        logic [TAG_W-1:0] tag;
        logic [31:0]      res;
        logic             ovf;
    } rsp_t;

    rsp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_rsp   = 0;
    logic [TAG_W-1:0] tagc = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic rsp_t model(input logic id, input logic [TAG_W-1:0] tag,
                                   input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        rsp_t r;
        r.id = id; r.tag = tag; r.res = '0; r.ovf = 1'b0;
        case (op)
            4'd0:  begin r.res = a + b; r.ovf = (a[31] == b[31]) && (r.res[31] != a[31]); end
            4'd1:  r.res = a + b;
            4'd2:  r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:  r.res = (a < b) ? 32'd1 : 32'd0;
            4'd4:  begin r.res = a - b; r.ovf = (a[31] != b[31]) && (r.res[31] != a[31]); end
            4'd5:  r.res = a - b;
            4'd6:  r.res = a & b;
            4'd7:  r.res = a | b;
            4'd8:  r.res = a ^ b;
            4'd9:  r.res = ~(a | b);
            4'd10: r.res = b << a[4:0];
            4'd11: r.res = b >> a[4:0];
            4'd12: r.res = 32'($signed(b) >>> a[4:0]);
            default: r.res = '0;
        endcase
        return r;
    endfunction

    // Scoreboard: expectations pushed on accept, popped on delivered response.
    always @(negedge clk) begin
        if (!resetn || flush) begin
            sb.delete();
        end else begin
            chk("one_ready", req0_ready & req1_ready, 0);
            if (rsp_valid && rsp_ready) begin
                rsp_t e;
                n_rsp++;
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_tag", rsp_tag, e.tag);
                    chk("rsp_result", rsp_result, e.res);
                    chk("rsp_ovf", rsp_ovf, e.ovf);
                end
            end
            if (req0_valid && req0_ready) sb.push_back(model(1'b0, req0_tag, req0_op, req0_a, req0_b));
            if (req1_valid && req1_ready) sb.push_back(model(1'b1, req1_tag, req1_op, req1_a, req1_b));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic port, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAG_W-1:0] tag);
        if (port) begin req1_op = op; req1_a = a; req1_b = b; req1_tag = tag; end
        else      begin req0_op = op; req0_a = a; req0_b = b; req0_tag = tag; end
    endtask

    task automatic set_rand(input logic port);
        tagc = tagc + 1'b1;
        set_req(port, 4'($urandom_range(0, 15)), $urandom, $urandom, tagc);
    endtask

    task automatic send(input logic port, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] tag);
        bit done = 1'b0;
        set_req(port, op, a, b, tag);
        if (port) req1_valid = 1'b1; else req0_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            done = port ? req1_ready : req0_ready;
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("send_accept", done, 1);
    endtask

    task automatic send_check(input string name, input logic port, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag,
                              input logic [31:0] exp_res, input logic exp_ovf);
        send(port, op, a, b, tag);
        chk({name, "_lat1"}, rsp_valid, 0);
        tick();
        chk({name, "_lat2"}, rsp_valid, 1);
        chk({name, "_res"}, rsp_result, exp_res);
        chk({name, "_ovf"}, rsp_ovf, exp_ovf);
        chk({name, "_id"}, rsp_id, port);
        chk({name, "_tag"}, rsp_tag, tag);
        tick();
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, exp_port, rsp_base;
        logic g0, g1;

        // Reset state
        req0_valid = 1'b1;
        #2;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_ovf", rsp_ovf, 0);
        chk("rst_req0_ready", req0_ready, 1);
        req0_valid = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        rsp_ready = 1'b1;

        // Directed ALU cases with latency
        send_check("add_ovf",  1'b0, 4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 4'd3, 32'h8000_0000, 1'b1);
        send_check("addu",     1'b0, 4'd1,  32'h7FFF_FFFF, 32'h0000_0001, 4'd4, 32'h8000_0000, 1'b0);
        send_check("slt",      1'b1, 4'd2,  32'hFFFF_FFFF, 32'h0000_0001, 4'd5, 32'h0000_0001, 1'b0);
        send_check("sltu",     1'b1, 4'd3,  32'hFFFF_FFFF, 32'h0000_0001, 4'd6, 32'h0000_0000, 1'b0);
        send_check("sra",      1'b0, 4'd12, 32'h0000_0004, 32'h8000_0000, 4'd7, 32'hF800_0000, 1'b0);
        send_check("sub_ovf",  1'b1, 4'd4,  32'h8000_0000, 32'h0000_0001, 4'd8, 32'h7FFF_FFFF, 1'b1);
        send_check("bad_op",   1'b0, 4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 4'd9, 32'h0000_0000, 1'b0);

        // Every opcode, random operands, alternating ports (scoreboard checked)
        for (int op = 0; op < 16; op++) begin
            tagc = tagc + 1'b1;
            send(op[0], 4'(op), $urandom, $urandom, tagc);
        end
        repeat (4) tick();

        // Arbitration from reset: both valid every cycle
        do_reset();
        rsp_base = n_rsp;
        set_rand(1'b0);
        set_rand(1'b1);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        acc = 0;
        exp_port = 0;
        for (int k = 0; k < 40 && acc < 8; k++) begin
            @(negedge clk);
            chk("arb_ready0", req0_ready, exp_port == 0);
            chk("arb_ready1", req1_ready, exp_port == 1);
            if (k >= 2) chk("arb_stream", rsp_valid, 1);
            g0 = req0_ready;
            g1 = req1_ready;
            tick();
            if (g0) set_rand(1'b0);
            if (g1) set_rand(1'b1);
            if (g0 || g1) begin acc++; exp_port = exp_port ^ 1; end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("arb_accepts", acc, 8);
        repeat (4) tick();
        chk("arb_rsp_count", n_rsp - rsp_base, 8);

        // Backpressure on port 1
        rsp_base = n_rsp;
        rsp_ready = 1'b0;
        set_rand(1'b1);
        req1_valid = 1'b1;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            g1 = req1_ready;
            tick();
            if (g1) begin acc++; set_rand(1'b1); end
        end
        chk("bp_accepts", acc, 3);
        @(negedge clk);
        chk("bp_ready_low", req1_ready, 0);
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_pop_cycle", req1_ready, 0);
        tick();
        @(negedge clk);
        chk("bp_ready_resume", req1_ready, 1);
        g1 = req1_ready;
        tick();
        if (g1) begin acc++; set_rand(1'b1); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            g1 = req1_ready;
            tick();
            if (g1) begin acc++; set_rand(1'b1); end
        end
        req1_valid = 1'b0;
        repeat (5) tick();
        chk("bp_rsp_count", n_rsp - rsp_base, acc);
        chk("bp_sb_empty", sb.size(), 0);

        // Flush with the queue and S1 occupied
        rsp_ready = 1'b0;
        set_rand(1'b0);
        req0_valid = 1'b1;
        acc = 0;
        for (int k = 0; k < 20 && acc < 3; k++) begin
            @(negedge clk);
            g0 = req0_ready;
            tick();
            if (g0) begin acc++; set_rand(1'b0); end
        end
        chk("fl_fill", acc, 3);
        flush = 1'b1;
        rsp_ready = 1'b1;
        rsp_base = n_rsp;
        @(negedge clk);
        chk("fl_ready0", req0_ready, 0);
        chk("fl_ready1", req1_ready, 0);
        tick();
        flush = 1'b0;
        req0_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("fl_rsp_valid", rsp_valid, 0);
            tick();
        end
        chk("fl_no_rsp", n_rsp - rsp_base, 0);
        send_check("post_flush", 1'b1, 4'd7, 32'h0F0F_0000, 32'h0000_00F0, 4'd11, 32'h0F0F_00F0, 1'b0);

        // Reset mid-stream
        set_rand(1'b0);
        set_rand(1'b1);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            g0 = req0_ready;
            g1 = req1_ready;
            tick();
            if (g0) set_rand(1'b0);
            if (g1) set_rand(1'b1);
        end
        chk("mr_busy", rsp_valid, 1);
        #2;
        resetn = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("mr_rsp_valid", rsp_valid, 0);
        chk("mr_rsp_id", rsp_id, 0);
        chk("mr_rsp_tag", rsp_tag, 0);
        chk("mr_rsp_result", rsp_result, 0);
        chk("mr_rsp_ovf", rsp_ovf, 0);
        tick();
        tick();
        @(negedge clk);
        resetn = 1'b1;
        tick();
        send_check("post_reset", 1'b1, 4'd6, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'd12, 32'h0F00_0F00, 1'b0);

        repeat (4) tick();
        chk("final_sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
